// File: rtl/mux_scan_nto1.sv
// N-to-1 channel multiplexer with a manual-select mode and an auto-scan mode.
// Scan mode streams channels 0..CHANNELS-1 over a valid/ready handshake.
module mux_scan_nto1 #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] In,
  input  logic [SEL_W-1:0]          Sel,
  input  logic                      Mode,
  input  logic                      Start,
  input  logic                      Out_ready,
  output logic [WIDTH-1:0]          Out,
  output logic                      Out_valid,
  output logic [SEL_W-1:0]          Cur_sel,
  output logic                      Scan_done
);

  typedef enum logic [1:0] {
    IDLE,
    MANUAL,
    SCAN
  } state_t;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] out_nx;
  logic [SEL_W-1:0] cur_nx;
  logic             valid_nx;
  logic             done_nx;

  logic [SEL_W-1:0] mux_idx;
  logic [WIDTH-1:0] mux_data;

  // The channel to load next depends only on state and inputs, so the mux
  // address is resolved separately from the FSM to keep the logic acyclic.
  always_comb begin : mux_addr
    mux_idx = Sel;
    if (state == SCAN) begin
      mux_idx = Cur_sel + 1'b1;
    end else if (state == IDLE && Mode) begin
      mux_idx = '0;
    end
  end

  // Indices at or beyond CHANNELS match no channel and fall through to zero.
  always_comb begin : channel_mux
    mux_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (mux_idx == SEL_W'(k)) begin
        mux_data = In[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin : fsm_next
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_nx = state;
    out_nx   = Out;
    cur_nx   = Cur_sel;
    valid_nx = Out_valid;
    done_nx  = 1'b0;

    unique case (state)
      IDLE: begin
        valid_nx = 1'b0;
        if (!Mode) begin
          state_nx = MANUAL;
          out_nx   = mux_data;
          cur_nx   = Sel;
          valid_nx = 1'b1;
        end else if (Start) begin
          state_nx = SCAN;
          out_nx   = mux_data;
          cur_nx   = '0;
          valid_nx = 1'b1;
        end
      end

      MANUAL: begin
        if (Mode) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
        end else begin
          out_nx   = mux_data;
          cur_nx   = Sel;
          valid_nx = 1'b1;
        end
      end

      SCAN: begin
        if (!Mode) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
        end else if (Out_valid && Out_ready) begin
          if (Cur_sel == LAST_IDX) begin
            state_nx = IDLE;
            valid_nx = 1'b0;
            done_nx  = 1'b1;
          end else begin
            out_nx   = mux_data;
            cur_nx   = Cur_sel + 1'b1;
            valid_nx = 1'b1;
          end
        end
      end

      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state     <= IDLE;
      Out       <= '0;
      Cur_sel   <= '0;
      Out_valid <= 1'b0;
      Scan_done <= 1'b0;
    end else begin
      state     <= state_nx;
      Out       <= out_nx;
      Cur_sel   <= cur_nx;
      Out_valid <= valid_nx;
      Scan_done <= done_nx;
    end
  end

endmodule

// File: doc/mux_scan_nto1.md
MUX_SCAN_NTO1 -- requirements
Module: mux_scan_nto1

Interface
REQ-001 SHALL have parameter WIDTH, default 1: bits per input channel and output.
REQ-002 SHALL have parameter CHANNELS, default 16, legal range 2..256: number of input channels.
REQ-003 SHALL have parameter SEL_W, default 4, equal to ceil(log2(CHANNELS)): select and index width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port In, input, CHANNELS*WIDTH bits: channel k occupies In[k*WIDTH +: WIDTH].
REQ-007 SHALL have port Sel, input, SEL_W bits: channel select in manual mode.
REQ-008 SHALL have port Mode, input, 1 bit: 0 = manual, 1 = scan.
REQ-009 SHALL have port Start, input, 1 bit: scan request, acted on only in IDLE with Mode=1.
REQ-010 SHALL have port Out_ready, input, 1 bit: downstream accept.
REQ-011 SHALL have port Out, output, WIDTH bits: registered selected channel data.
REQ-012 SHALL have port Out_valid, output, 1 bit: Out holds a valid sample.
REQ-013 SHALL have port Cur_sel, output, SEL_W bits: channel index of the sample on Out.
REQ-014 SHALL have port Scan_done, output, 1 bit: one-cycle pulse after the last scan beat is accepted.

Function
REQ-015 SHALL implement a state machine with three states, IDLE, MANUAL and SCAN, all outputs registered.
REQ-016 IDLE transitions:
  - Mode=0 -> MANUAL next cycle.
  - Mode=1 with Start=1 -> SCAN next cycle.
  - otherwise stay in IDLE, with Out_valid=0 and Out and Cur_sel holding their values.
REQ-017 MANUAL SHALL register Out <= channel Sel and Cur_sel <= Sel every cycle (latency 1 clock), hold Out_valid=1 and ignore Out_ready.
REQ-018 MANUAL with Mode=1 -> IDLE next cycle, with Out_valid=0.
REQ-019 On SCAN entry, Out SHALL be loaded with channel 0, Cur_sel=0 and Out_valid=1.
REQ-020 In SCAN, a beat is accepted on any clock where Out_valid=1 and Out_ready=1.
  - Accepted beat with Cur_sel<CHANNELS-1: load channel Cur_sel+1 next cycle.
  - Accepted beat with Cur_sel=CHANNELS-1: go to IDLE next cycle, with Scan_done=1 for exactly that cycle and Out_valid=0.
REQ-021 During a SCAN stall (Out_valid=1, Out_ready=0), Out and Cur_sel SHALL hold stable, and changes on In SHALL NOT affect Out until the next load.
REQ-022 Start SHALL be ignored outside IDLE; Start held high continuously SHALL restart a new scan from IDLE each time one completes.
REQ-023 Mode=0 while in SCAN SHALL abort the scan: next cycle IDLE, Out_valid=0, Scan_done=0.
REQ-024 Any select value of CHANNELS or above (Sel in MANUAL) SHALL produce Out=0; Cur_sel SHALL still report the raw Sel value.
REQ-025 Index arithmetic SHALL be SEL_W-bit unsigned and SHALL never wrap within a scan; termination is by the compare in REQ-020.
REQ-026 Scan_done SHALL be 0 in every cycle other than the one defined in REQ-020.

Reset
REQ-027 reset=1 at a rising edge SHALL force the following, overriding all other inputs in that cycle:
  - state=IDLE;
  - Out=0, Cur_sel=0;
  - Out_valid=0, Scan_done=0.
REQ-028 reset asserted mid-scan SHALL discard the scan with no Scan_done pulse; a new scan SHALL require a fresh Start after reset deasserts.

Verification
REQ-029 Manual sweep: WIDTH=1, CHANNELS=16, In=16'hAAAA, Mode=0, Sel stepped 0..15 every 5 cycles -> Out equals Sel[0] (0,1,0,1,...) one cycle after each Sel change; Out_valid=1 throughout.
REQ-030 Full-rate scan: In=16'hAAAA, Mode=1, one-cycle Start pulse, Out_ready=1 -> exactly 16 consecutive valid beats with Cur_sel 0..15 and Out 0,1,0,1,...; Scan_done=1 the cycle after beat 15.
REQ-031 Backpressure: WIDTH=8, CHANNELS=4, In=32'h44332211, Out_ready toggled 0/1 and In changed during the stall -> accepted sequence 8'h11, 8'h22, 8'h33, 8'h44 with Out stable while stalled; exactly one Scan_done pulse.
REQ-032 Out-of-range select: CHANNELS=12, WIDTH=4, all channels 4'hF, Mode=0, Sel=13 -> Out=4'h0 and Cur_sel=13; Sel=11 -> Out=4'hF.
REQ-033 Reset mid-scan: reset asserted at Cur_sel=5 -> next cycle Out=0, Out_valid=0, Cur_sel=0, no Scan_done; a later Start scans from channel 0.
REQ-034 Abort and ignored Start: Start pulsed again at Cur_sel=3 -> no restart, scan continues to 15; in a second scan, Mode=0 at Cur_sel=7 -> IDLE, no Scan_done, then MANUAL one cycle later.
